load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage front end of the five-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the byte-addressed data memory.
- Every memory access is issued as an aligned 32-bit word access (MemOp 3'b010).
- Byte and halfword loads get their lane selected and sign- or zero-extended here.
- Sub-word stores are done as read-modify-write, so neighbouring bytes are preserved.
- Stalls the pipeline during multi-cycle operations and reports misaligned, out-of-range and illegal accesses.

Parameters:
DM_DEPTH, 256, data memory size in bytes; power of two, minimum 4.
ADDR_W, 32, address and data width; fixed at 32.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  EX/MEM holds a valid memory instruction.
req_read  input  1  load request.
req_write  input  1  store request.
req_op  input  3  funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
req_addr  input  32  byte address.
req_wdata  input  32  store data (rs2).
req_rd  input  5  load destination register.
stall  output  1  hold IF..EX/MEM (combinational).
wb_valid  output  1  load result valid (registered, one-cycle pulse).
wb_data  output  32  extended load result.
wb_rd  output  5  destination of wb_data.
exc_valid  output  1  access exception pulse (registered).
exc_cause  output  2  01 misaligned, 10 out of range, 11 illegal op.
exc_addr  output  32  faulting req_addr.
dm_memop  output  3  always 3'b010.
dm_addr  output  32  {addr[31:2],2'b00}.
dm_wdata  output  32  word to write.
dm_memread  output  1  read strobe.
dm_memwrite  output  1  write strobe.
dm_rdata  input  32  memory read data; valid the cycle after the address is presented.

Behaviour:
- Reset: synchronous, active-high. state=IDLE; wb_valid, exc_valid, wb_data, wb_rd, exc_cause, exc_addr all 0. While rst=1, dm_memwrite, dm_memread and stall are forced to 0.
- Reset mid-operation: the operation is abandoned and memory is left unmodified, because the only write happens in RMW_WR and is gated by rst.
- Request accepted: only in IDLE with req_valid=1. In any other state the request inputs are ignored; the pipeline holds them stable while stall=1.
- Checks at acceptance, in priority order:
  1. Illegal op → cause 11. Illegal means req_op ∈ {011,110,111}, or req_read and req_write both set, or req_write with op 100/101.
  2. Misaligned → cause 01. Halfword with addr[0]=1, or word with addr[1:0]≠0.
  3. Out of range → cause 10. Word-aligned address ≥ DM_DEPTH.
- On any fault:
  - No dm strobe is driven.
  - exc_valid=1 the next cycle, with exc_cause and exc_addr.
  - stall=0; no wb_valid.
- States: IDLE, LOAD, RMW_RD, RMW_WR.
- Word store (sw):
  - Handled entirely in IDLE: dm_memwrite=1, dm_wdata=req_wdata.
  - stall=0; single cycle; stays in IDLE.
- Load:
  - IDLE: dm_memread=1, stall=1. Latch op, byte offset and rd. Go to LOAD.
  - LOAD: select the lane from dm_rdata using the latched offset. Byte lane = offset; halfword lane = offset[1]. Extend per op.
  - At the end of LOAD, register wb_data and wb_rd and set wb_valid=1. stall=0 during LOAD. Go to IDLE.
  - wb_valid is high in the cycle two cycles after the request cycle.
- Sub-word store (sb/sh):
  - IDLE: dm_memread=1, stall=1. Latch wdata, op and offset. Go to RMW_RD.
  - RMW_RD: merge req_wdata[7:0] or [15:0] into the selected lane of dm_rdata. Register the merged word; stall=1. Go to RMW_WR.
  - RMW_WR: dm_memwrite=1, dm_wdata=merged word, stall=0. Go to IDLE.
  - Total 3 cycles.
- Back-to-back requests: a new request may be accepted in the cycle after LOAD or RMW_WR (IDLE). There is no bubble beyond the stall cycles.
- Addresses above DM_DEPTH are never presented to memory.
- dm_addr wrap at the top word, DM_DEPTH-4, is legal and must not touch other words.
- exc_valid and wb_valid are never high in the same cycle.

Test Plan:
1. Store then reload a word:
   - Stimulus: sw 0xDEADBEEF at 0x10, then lw 0x10.
   - Response: sw has no stall. wb_data=0xDEADBEEF, wb_rd as issued, wb_valid two cycles after the load request; one stall cycle.
2. Byte store preserves neighbours:
   - Stimulus: with 0x11223344 at 0x20, issue sb 0xAA at 0x22.
   - Response: stall for 2 cycles; memory word becomes 0x11AA3344. Then lb 0x22 returns 0xFFFFFFAA and lbu 0x22 returns 0x000000AA.
3. Halfword store and loads:
   - Stimulus: sh 0x8001 at 0x22, then lh 0x22 and lhu 0x22.
   - Response: lh returns 0xFFFF8001; lhu returns 0x00008001; word at 0x20 is 0x80013344.
4. Faults:
   - Stimulus: lw 0x13, lh 0x21, sw 0x100 with DM_DEPTH=256, and op 011.
   - Response: exc_cause 01, 01, 10, 11 respectively; exc_addr equals the request address; dm_memwrite never asserted; no wb_valid.
5. Reset aborts a read-modify-write:
   - Stimulus: assert rst during RMW_RD of sb 0x55 at 0x21.
   - Response: memory word is unchanged; state is IDLE; all outputs 0 the next cycle.
6. Back-to-back sb and lw at the top word:
   - Stimulus: sb at 0xFC, immediately followed by lw 0xFC.
   - Response: lw is accepted in the cycle after RMW_WR and returns the merged word.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues aligned word accesses, extends sub-word loads,
// performs read-modify-write for sb/sh, and flags illegal/misaligned/out-of-range accesses.
module load_store_unit #(
  parameter int unsigned DM_DEPTH = 256,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [2:0]        dm_memop,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [ADDR_W-1:0] dm_wdata,
  output logic              dm_memread,
  output logic              dm_memwrite,
  input  logic [ADDR_W-1:0] dm_rdata
);

  localparam logic [2:0] OP_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, RMW_WR} state_t;

  state_t            state, state_d;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] merged_q;

  logic [ADDR_W-1:0] word_addr;
  logic              req_act, illegal, misaligned, out_of_range, fault;
  logic              capture, exc_set;
  logic [1:0]        cause_d;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [ADDR_W-1:0] load_res;
  logic [ADDR_W-1:0] merged;

  assign dm_memop  = OP_WORD;
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign req_act   = req_valid && (req_read || req_write);

  // Acceptance checks; cause encoding follows priority illegal > misaligned > range.
  assign illegal      = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111) ||
                        (req_read && req_write) || (req_write && req_op[2]);
  assign misaligned   = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign out_of_range = word_addr >= ADDR_W'(DM_DEPTH);
  assign fault        = illegal || misaligned || out_of_range;
  assign cause_d      = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b10);

  assign byte_sel = dm_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = dm_rdata[{off_q[1], 4'b0000} +: 16];

  // Lane extension for loads.
  always_comb begin
    load_res = dm_rdata;
    case (op_q)
      3'b000:  load_res = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_res = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_res = {24'd0, byte_sel};
      3'b101:  load_res = {16'd0, half_sel};
      default: load_res = dm_rdata;
    endcase
  end

  // Merge store data into the selected lane of the word read back.
  always_comb begin
    merged = dm_rdata;
    if (op_q[1:0] == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d     = state;
    stall       = 1'b0;
    dm_memread  = 1'b0;
    dm_memwrite = 1'b0;
    dm_addr     = word_addr;
    dm_wdata    = req_wdata;
    capture     = 1'b0;
    exc_set     = 1'b0;
    case (state)
      IDLE: begin
        if (req_act) begin
          if (fault) begin
            exc_set = 1'b1;
          end else if (req_read) begin
            dm_memread = 1'b1;
            stall      = 1'b1;
            capture    = 1'b1;
            state_d    = LOAD;
          end else if (req_op == OP_WORD) begin
            dm_memwrite = 1'b1;
          end else begin
            dm_memread = 1'b1;
            stall      = 1'b1;
            capture    = 1'b1;
            state_d    = RMW_RD;
          end
        end
      end
      LOAD:   state_d = IDLE;
      RMW_RD: begin
        stall   = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        dm_memwrite = 1'b1;
        dm_addr     = waddr_q;
        dm_wdata    = merged_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons any operation without touching memory.
    if (rst) begin
      stall       = 1'b0;
      dm_memread  = 1'b0;
      dm_memwrite = 1'b0;
      exc_set     = 1'b0;
      capture     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      merged_q  <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
    end else begin
      state     <= state_d;
      wb_valid  <= (state == LOAD);
      exc_valid <= exc_set;
      if (capture) begin
        op_q    <= req_op;
        off_q   <= req_addr[1:0];
        rd_q    <= req_rd;
        wdata_q <= req_wdata[15:0];
        waddr_q <= word_addr;
      end
      if (state == LOAD) begin
        wb_data <= load_res;
        wb_rd   <= rd_q;
      end
      if (state == RMW_RD) merged_q <= merged;
      if (exc_set) begin
        exc_cause <= cause_d;
        exc_addr  <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and
// random requests checked against a byte-array reference model.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 256;

  localparam int K_FAULT = 0;
  localparam int K_LOAD  = 1;
  localparam int K_SW    = 2;
  localparam int K_SUB   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_read, req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, wb_valid, exc_valid, dm_memread, dm_memwrite;
  logic [31:0] wb_data, exc_addr, dm_addr, dm_wdata, dm_rdata;
  logic [4:0]  wb_rd;
  logic [1:0]  exc_cause;
  logic [2:0]  dm_memop;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [31:0] dm_mem  [DEPTH/4];
  logic [7:0]  ref_mem [DEPTH];

  load_store_unit #(.DM_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
    .dm_memop(dm_memop), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_memread(dm_memread), .dm_memwrite(dm_memwrite), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, word write.
  always @(posedge clk) begin
    if (dm_memwrite) dm_mem[(dm_addr / 4) % (DEPTH / 4)] <= dm_wdata;
    if (dm_memread)  dm_rdata <= dm_mem[(dm_addr / 4) % (DEPTH / 4)];
  end

  // Invariants watched every cycle.
  always @(negedge clk) begin
    if ((dm_memread || dm_memwrite) && dm_addr >= DEPTH) viol++;
    if (wb_valid && exc_valid) viol++;
    if (dm_memop !== 3'b010) viol++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-addressed memory with RISC-V access rules.
  task automatic model(input logic r, input logic w, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int kind, output logic [1:0] cause, output logic [31:0] data);
    int size;
    longint v;
    int wa;
    size  = (op[1:0] == 2'b00) ? 1 : ((op[1:0] == 2'b01) ? 2 : 4);
    kind  = K_FAULT;
    cause = 2'b00;
    data  = 32'd0;
    if (op == 3'd3 || op == 3'd6 || op == 3'd7 || (r && w) || (w && op >= 3'd4)) cause = 2'b11;
    else if (a % size != 0) cause = 2'b01;
    else if ((a / 4) * 4 >= DEPTH) cause = 2'b10;
    else if (r) begin
      kind = K_LOAD;
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
      if (!op[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      data = v[31:0];
    end else begin
      kind = (size == 4) ? K_SW : K_SUB;
      for (int i = 0; i < size; i++) ref_mem[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
      wa = int'(a) & ~3;
      data = {ref_mem[wa + 3], ref_mem[wa + 2], ref_mem[wa + 1], ref_mem[wa]};
    end
  endtask

  // Issue one request from IDLE and follow it to completion.
  task automatic do_req(input string nm, input logic r, input logic w, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdn,
                        input int kind, input logic [1:0] cause, input logic [31:0] data);
    req_valid = 1'b1; req_read = r; req_write = w; req_op = op;
    req_addr = a; req_wdata = wd; req_rd = rdn;
    #1;
    check({nm, ".stall"}, 32'(stall), 32'((kind == K_LOAD) || (kind == K_SUB)));
    case (kind)
      K_FAULT: begin
        check({nm, ".strobe"}, 32'(dm_memread | dm_memwrite), 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check({nm, ".exc_valid"}, 32'(exc_valid), 32'd1);
        check({nm, ".exc_cause"}, 32'(exc_cause), 32'(cause));
        check({nm, ".exc_addr"}, exc_addr, a);
        check({nm, ".wb_valid"}, 32'(wb_valid), 32'd0);
      end
      K_SW: begin
        check({nm, ".memwrite"}, 32'(dm_memwrite), 32'd1);
        check({nm, ".wdata"}, dm_wdata, wd);
        check({nm, ".addr"}, dm_addr, a & 32'hFFFF_FFFC);
        tick();
        req_valid = 1'b0;
        #1;
      end
      K_LOAD: begin
        check({nm, ".memread"}, 32'(dm_memread), 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        check({nm, ".load_stall"}, 32'(stall), 32'd0);
        check({nm, ".early_wb"}, 32'(wb_valid), 32'd0);
        tick();
        #1;
        check({nm, ".wb_valid"}, 32'(wb_valid), 32'd1);
        check({nm, ".wb_data"}, wb_data, data);
        check({nm, ".wb_rd"}, 32'(wb_rd), 32'(rdn));
      end
      default: begin
        check({nm, ".memread"}, 32'(dm_memread), 32'd1);
        tick();
        #1;
        check({nm, ".rmw_stall"}, 32'(stall), 32'd1);
        check({nm, ".rmw_nowrite"}, 32'(dm_memwrite), 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check({nm, ".wr_stall"}, 32'(stall), 32'd0);
        check({nm, ".wr_strobe"}, 32'(dm_memwrite), 32'd1);
        check({nm, ".wr_addr"}, dm_addr, a & 32'hFFFF_FFFC);
        check({nm, ".wr_data"}, dm_wdata, data);
        tick();
      end
    endcase
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          kind;
    logic [1:0]  cause;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          mk;
    logic [1:0]  mc;
    logic [31:0] md;
    logic        rr, ww;
    logic [2:0]  op;
    logic [31:0] a, wd;
    logic [4:0]  rdn;
    int          sel;

    for (int i = 0; i < int'(DEPTH / 4); i++) dm_mem[i] = 32'd0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'd0;
    dm_rdata = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;

    tick(); tick();
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.strobes", 32'(dm_memread | dm_memwrite), 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.exc_valid", 32'(exc_valid), 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.exc_addr", exc_addr, 32'd0);
    rst = 1'b0;
    tick();

    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 5'd0,  K_SW,    2'b00, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        5'd5,  K_LOAD,  2'b00, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h20,  32'h11223344, 5'd0,  K_SW,    2'b00, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h22,  32'h000000AA, 5'd0,  K_SUB,   2'b00, 32'h11AA3344});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h20,  32'h0,        5'd6,  K_LOAD,  2'b00, 32'h11AA3344});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32'h22,  32'h0,        5'd7,  K_LOAD,  2'b00, 32'hFFFFFFAA});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h22,  32'h0,        5'd8,  K_LOAD,  2'b00, 32'h000000AA});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 32'h22,  32'h12348001, 5'd0,  K_SUB,   2'b00, 32'h80013344});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h22,  32'h0,        5'd9,  K_LOAD,  2'b00, 32'hFFFF8001});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 32'h22,  32'h0,        5'd10, K_LOAD,  2'b00, 32'h00008001});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h20,  32'h0,        5'd11, K_LOAD,  2'b00, 32'h80013344});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h13,  32'h0,        5'd1,  K_FAULT, 2'b01, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h21,  32'h0,        5'd1,  K_FAULT, 2'b01, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h100, 32'h5,        5'd0,  K_FAULT, 2'b10, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd3, 32'h10,  32'h0,        5'd1,  K_FAULT, 2'b11, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'h10,  32'h0,        5'd1,  K_FAULT, 2'b11, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 32'h10,  32'h0,        5'd0,  K_FAULT, 2'b11, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd7, 32'h3,   32'h0,        5'd1,  K_FAULT, 2'b11, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        5'd1,  K_FAULT, 2'b01, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h100, 32'h0,        5'd1,  K_FAULT, 2'b10, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'hFC,  32'h01020304, 5'd0,  K_SW,    2'b00, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'hFF,  32'hFFFFFF55, 5'd0,  K_SUB,   2'b00, 32'h55020304});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'hFC,  32'h0,        5'd31, K_LOAD,  2'b00, 32'h55020304});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'hFE,  32'h0,        5'd12, K_LOAD,  2'b00, 32'h00005502});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32'hFD,  32'h0,        5'd13, K_LOAD,  2'b00, 32'h00000003});

    foreach (tbl[i]) begin
      model(tbl[i].r, tbl[i].w, tbl[i].op, tbl[i].addr, tbl[i].wdata, mk, mc, md);
      do_req($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].op, tbl[i].addr,
             tbl[i].wdata, tbl[i].rd, tbl[i].kind, tbl[i].cause, tbl[i].data);
    end

    // Reset during RMW_RD of sb 0x55 at 0x21 must leave memory untouched.
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_op = 3'd0;
    req_addr = 32'h21; req_wdata = 32'h55; req_rd = 5'd0;
    tick();
    rst = 1'b1;
    #1;
    check("rstrmw.stall", 32'(stall), 32'd0);
    check("rstrmw.strobes", 32'(dm_memread | dm_memwrite), 32'd0);
    tick();
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    #1;
    check("rstrmw.stall_after", 32'(stall), 32'd0);
    check("rstrmw.wb_valid", 32'(wb_valid), 32'd0);
    check("rstrmw.wb_data", wb_data, 32'd0);
    check("rstrmw.wb_rd", 32'(wb_rd), 32'd0);
    check("rstrmw.exc_valid", 32'(exc_valid), 32'd0);
    check("rstrmw.exc_cause", 32'(exc_cause), 32'd0);
    check("rstrmw.exc_addr", exc_addr, 32'd0);
    tick();
    check("rstrmw.strobes_idle", 32'(dm_memread | dm_memwrite), 32'd0);
    check("rstrmw.mem_word", dm_mem[32'h20 / 4], 32'h80013344);
    do_req("rstrmw.reload", 1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 5'd3, K_LOAD, 2'b00, 32'h80013344);

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      rr  = (sel < 5) || (sel == 9);
      ww  = (sel >= 5);
      op  = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 7));
      wd  = $urandom;
      rdn = 5'($urandom_range(0, 31));
      model(rr, ww, op, a, wd, mk, mc, md);
      do_req($sformatf("rnd%0d", n), rr, ww, op, a, wd, rdn, mk, mc, md);
      if ($urandom_range(0, 3) == 0) tick();
    end

    for (int i = 0; i < int'(DEPTH / 4); i++)
      check($sformatf("final_mem%0d", i), dm_mem[i],
            {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    check("invariants", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
